// File: rtl/amiga_clk_model.sv
// amiga_clk_model
//   Behavioural stand-in for the Amiga PLL/divider chain. It waits a fixed
//   number of reference cycles before declaring lock. It then derives a
//   28 MHz enable/clock and a 7 MHz counter from a 4-slot frame.
//
// Parameters
//   LOCK_CYCLES : reference cycles after reset or power-down before locked rises
//   PHASE       : frame slot (taken mod 4) in which c1_en fires
//
// Ports
//   inclk0   in   reference clock, all logic on rising edge
//   areset_n in   asynchronous active-low reset
//   pwrdwn   in   synchronous power-down request, drops lock on next edge
//   locked   out  divider chain running
//   c1_en    out  1-in-4 clock-enable pulse
//   c1       out  50 % duty divided clock, lags phase by one cycle
//   clk_7    out  2-bit counter advancing on each c1_en
//   c7_en    out  pulse on the c1_en at which clk_7 wraps 3 -> 0
//   phase    out  current frame slot
module amiga_clk_model #(
  parameter int LOCK_CYCLES = 64,
  parameter int PHASE       = 0
) (
  input  logic       inclk0,
  input  logic       areset_n,
  input  logic       pwrdwn,
  output logic       locked,
  output logic       c1_en,
  output logic       c1,
  output logic [1:0] clk_7,
  output logic       c7_en,
  output logic [1:0] phase
);

  // Reduce PHASE into 0..3, including negative values.
  localparam int          PH_INT    = ((PHASE % 4) + 4) % 4;
  localparam logic [1:0]  PH        = 2'(PH_INT);
  localparam logic [1:0]  PH_NEXT   = 2'(PH_INT + 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic [15:0] lock_cnt_r, lock_cnt_s;
  logic        locked_r, locked_s;
  logic [1:0]  phase_r, phase_s;
  logic [1:0]  clk_7_r, clk_7_s;
  logic        c1_en_r, c1_en_s;
  logic        c7_en_r, c7_en_s;
  logic        c1_r, c1_s;

  // Next-state: lock counting, then the frame outputs for the coming cycle.
  always_comb begin
    lock_cnt_s = lock_cnt_r;
    locked_s   = 1'b0;
    phase_s    = 2'd0;
    clk_7_s    = 2'd0;
    c1_en_s    = 1'b0;
    c7_en_s    = 1'b0;
    c1_s       = 1'b0;

    if (pwrdwn) begin
      lock_cnt_s = 16'd0;
    end else if (locked_r) begin
      locked_s = 1'b1;
    end else if (lock_cnt_r == LOCK_LAST) begin
      locked_s = 1'b1;
    end else begin
      lock_cnt_s = lock_cnt_r + 16'd1;
    end

    // The enables are precomputed from the next phase so that they line up
    // with phase while still coming straight from flops.
    if (locked_s) begin
      if (locked_r) begin
        phase_s = phase_r + 2'd1;
      end else begin
        phase_s = 2'd0;
      end
      clk_7_s = clk_7_r + {1'b0, c1_en_r};
      c1_en_s = (phase_s == PH);
      c7_en_s = c1_en_s && (clk_7_s == 2'd3);
      // c1 follows the phase of the cycle just ending, so it lags by one.
      c1_s    = locked_r && ((phase_r == PH) || (phase_r == PH_NEXT));
    end else begin
      phase_s = 2'd0;
      clk_7_s = 2'd0;
      c1_en_s = 1'b0;
      c7_en_s = 1'b0;
      c1_s    = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously by areset_n.
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
      phase_r    <= 2'd0;
      clk_7_r    <= 2'd0;
      c1_en_r    <= 1'b0;
      c7_en_r    <= 1'b0;
      c1_r       <= 1'b0;
    end else begin
      lock_cnt_r <= lock_cnt_s;
      locked_r   <= locked_s;
      phase_r    <= phase_s;
      clk_7_r    <= clk_7_s;
      c1_en_r    <= c1_en_s;
      c7_en_r    <= c7_en_s;
      c1_r       <= c1_s;
    end
  end

  assign locked = locked_r;
  assign c1_en  = c1_en_r;
  assign c1     = c1_r;
  assign clk_7  = clk_7_r;
  assign c7_en  = c7_en_r;
  assign phase  = phase_r;

endmodule

// File: tb/tb_amiga_clk_model.sv
// tb_amiga_clk_model
//   Four instances share one stimulus:
//     0: LOCK=64, PHASE=0
//     1: LOCK=64, PHASE=2
//     2: LOCK=64, PHASE=6
//     3: LOCK=1,  PHASE=3
//   The reference model counts unlocked run length and the locked cycle
//   index k. Every output is derived arithmetically from k.
module tb_amiga_clk_model;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       pwrdwn;
  logic [3:0] locked_w, c1_en_w, c1_w, c7_en_w;
  logic [1:0] clk7_w  [4];
  logic [1:0] phase_w [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int lc   [4] = '{64, 64, 64, 1};
  int pm   [4] = '{0, 2, 6 % 4, 3};
  int run  [4];
  int kidx [4];

  always #5 clk = ~clk;

  amiga_clk_model #(.LOCK_CYCLES(64), .PHASE(0)) u0 (
    .inclk0(clk), .areset_n(areset_n), .pwrdwn(pwrdwn),
    .locked(locked_w[0]), .c1_en(c1_en_w[0]), .c1(c1_w[0]),
    .clk_7(clk7_w[0]), .c7_en(c7_en_w[0]), .phase(phase_w[0]));
  amiga_clk_model #(.LOCK_CYCLES(64), .PHASE(2)) u1 (
    .inclk0(clk), .areset_n(areset_n), .pwrdwn(pwrdwn),
    .locked(locked_w[1]), .c1_en(c1_en_w[1]), .c1(c1_w[1]),
    .clk_7(clk7_w[1]), .c7_en(c7_en_w[1]), .phase(phase_w[1]));
  amiga_clk_model #(.LOCK_CYCLES(64), .PHASE(6)) u2 (
    .inclk0(clk), .areset_n(areset_n), .pwrdwn(pwrdwn),
    .locked(locked_w[2]), .c1_en(c1_en_w[2]), .c1(c1_w[2]),
    .clk_7(clk7_w[2]), .c7_en(c7_en_w[2]), .phase(phase_w[2]));
  amiga_clk_model #(.LOCK_CYCLES(1), .PHASE(3)) u3 (
    .inclk0(clk), .areset_n(areset_n), .pwrdwn(pwrdwn),
    .locked(locked_w[3]), .c1_en(c1_en_w[3]), .c1(c1_w[3]),
    .clk_7(clk7_w[3]), .c7_en(c7_en_w[3]), .phase(phase_w[3]));

  // Output layout: {locked, c1_en, c1, c7_en, clk_7[1:0], phase[1:0]}.
  function automatic logic [7:0] expected(input int i);
    int         kk;
    int         p;
    int         n;
    logic       en;
    logic       c1v;
    logic       c7v;
    logic [1:0] clk7v;
    logic [1:0] phv;
    kk = kidx[i];
    p  = pm[i];
    if (kk < 0) return 8'h00;
    phv   = 2'(kk % 4);
    en    = ((kk % 4) == p);
    c1v   = (kk >= 1) && ((((kk - 1) % 4) == p) || (((kk - 1) % 4) == ((p + 1) % 4)));
    n     = (kk + 3 - p) / 4;        // c1_en pulses in cycles 0..kk-1
    clk7v = 2'(n % 4);
    c7v   = en && ((n % 4) == 3);
    return {1'b1, en, c1v, c7v, clk7v, phv};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      run[i]  = 0;
      kidx[i] = -1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (!areset_n || pwrdwn) begin
        run[i]  = 0;
        kidx[i] = -1;
      end else if (kidx[i] < 0) begin
        run[i] = run[i] + 1;
        if (run[i] >= lc[i]) kidx[i] = 0;
      end else begin
        kidx[i] = kidx[i] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] obs;
    logic [7:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      obs   = {locked_w[i], c1_en_w[i], c1_w[i], c7_en_w[i], clk7_w[i], phase_w[i]};
      exp_v = expected(i);
      checks++;
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s inst%0d cyc%0d observed=%h expected=%h", tag, i, cyc, obs, exp_v);
      end
    end
  endtask

  task automatic step(input logic pd, input string tag);
    pwrdwn = pd;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset();
    #2;
    areset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all("in_rst");
    areset_n = 1'b1;
  endtask

  initial begin
    areset_n = 1'b0;
    pwrdwn   = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    areset_n = 1'b1;

    // Lock acquisition and the first locked frames.
    for (int j = 0; j < 90; j++) step(1'b0, "lock");
    // Power-down for 3 cycles, then relock.
    for (int j = 0; j < 3; j++) step(1'b1, "pwrdwn");
    for (int j = 0; j < 80; j++) step(1'b0, "relock");
    // Asynchronous reset mid-operation, then relock.
    async_reset();
    for (int j = 0; j < 80; j++) step(1'b0, "rst_relock");
    // Random power-down pulses of random length.
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 79) == 0) begin
        for (int m = 0; m < int'($urandom_range(1, 4)); m++) step(1'b1, "rnd_pd");
      end else begin
        step(1'b0, "rnd");
      end
    end
    async_reset();
    for (int j = 0; j < 100; j++) step(1'b0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amiga_clk_model.md
AMIGA_CLK_MODEL -- requirements
Module: amiga_clk_model

Interface
REQ-001 Parameter LOCK_CYCLES, default 64: reference cycles after reset release before lock is declared (1..65535).
REQ-002 Parameter PHASE, default 0: phase slot 0..3 within each 4-cycle frame in which the 28 MHz enable fires.
REQ-003 inclk0  input  1  single clock, 114.77 MHz SDRAM-rate reference, all logic on rising edge.
REQ-004 areset_n  input  1  asynchronous, active-low reset.
REQ-005 pwrdwn  input  1  power-down request, synchronous, active-high.
REQ-006 locked  output  1  high when the divider chain is running and stable.
REQ-007 c1_en  output  1  one-cycle 28.69 MHz clock-enable pulse (1 in 4 inclk0 cycles).
REQ-008 c1  output  1  28.69 MHz square-wave divided clock, 50 % duty, registered.
REQ-009 clk_7  output  2  free-running 2-bit counter advancing once per c1_en; clk_7[1] is the 7.17 MHz clock.
REQ-010 c7_en  output  1  one-cycle pulse on the c1_en at which clk_7 wraps from 3 to 0.
REQ-011 phase  output  2  current slot (0..3) of the 4-cycle frame.

Function
REQ-012 Lock counter, 16 bits, increments each cycle while locked=0 and pwrdwn=0; locked SHALL rise on the cycle after the counter reaches LOCK_CYCLES-1, then the counter holds.
REQ-013 pwrdwn=1 SHALL clear locked and the lock counter on the next edge; relock then requires another LOCK_CYCLES cycles after pwrdwn returns to 0.
REQ-014 While locked=0: phase, clk_7, c1 SHALL hold 0; c1_en and c7_en SHALL be 0.
REQ-015 While locked=1: phase SHALL increment mod 4 every cycle, starting at 0 on the first locked cycle.
REQ-016 c1_en SHALL be 1 exactly in cycles where phase == PHASE.
REQ-017 c1 SHALL be 1 for phase values PHASE and PHASE+1 (mod 4), 0 for the other two, registered one cycle after phase.
REQ-018 clk_7 SHALL increment by 1 (mod 4) on each cycle in which c1_en=1; wrap 3->0 is silent.
REQ-019 c7_en SHALL be 1 in the same cycle as c1_en when clk_7 == 3 (the increment then wraps it to 0).
REQ-020 Loss of lock mid-frame (pwrdwn) SHALL immediately force REQ-014 values on the next edge; no partial pulses are emitted afterwards.
REQ-021 PHASE outside 0..3 SHALL be reduced mod 4.
REQ-022 All outputs SHALL be registered; no combinational path from pwrdwn to any output.

Reset
REQ-023 areset_n=0 SHALL asynchronously force locked=0, lock counter=0, phase=0, clk_7=0, c1=0, c1_en=0, c7_en=0.
REQ-024 Release of areset_n SHALL be sampled on inclk0; lock counting starts on the first edge with areset_n=1.
REQ-025 Reset asserted mid-operation SHALL take effect without waiting for a clock edge.

Verification
REQ-026 Reset release, LOCK_CYCLES=64, pwrdwn=0 -> locked=0 for 64 cycles, rises after 64th edge; phase 0,1,2,3,0 thereafter.
REQ-027 Locked, PHASE=0 -> c1_en pulses every 4th cycle at phase 0; c1 pattern 1,1,0,0 lagging phase by one cycle.
REQ-028 Locked, 16 cycles -> clk_7 steps 0,1,2,3,0; c7_en single pulse at the 3->0 step; clk_7[1] period 16 cycles.
REQ-029 PHASE=2 -> c1_en fires at phase 2 only; PHASE=6 behaves identically to PHASE=2.
REQ-030 pwrdwn pulsed for 3 cycles while locked -> locked=0 and outputs zero next edge; relock 64 cycles after pwrdwn drops.
REQ-031 areset_n pulsed low between clock edges while locked -> all outputs 0 immediately; relock after 64 cycles.
